// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the configurable UART receiver.
// UART_RX_BREAK_EN adds the BREAK state to the FSM enum.
package uart_rx_pkg;

  localparam int MIN_PRESCALE = 8;
  localparam int MIN_DATA_LEN = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
`ifdef UART_RX_BREAK_EN
    , ST_BREAK
`endif
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser, per-bit edge counter and three-sample majority register.
// bit_val is loaded at the end of edge h+1 and is stable from edge h+2.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr,
  output logic                  rx_sync,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  bit_val
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic                  sync1;
  logic [1:0]            smp;
  logic [PRESCALE_W-1:0] half;

  assign half = prescale >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync1   <= rx_in;
      rx_sync <= sync1;
    end
  end

  // Held at 0 while the FSM idles so the detection cycle is edge 0.
  always_ff @(posedge clk) begin
    if (rst || clr)                   edge_cnt <= '0;
    else if (edge_cnt == prescale - ONE) edge_cnt <= '0;
    else                              edge_cnt <= edge_cnt + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp     <= 2'b11;
      bit_val <= 1'b1;
    end else begin
      if (edge_cnt == half - ONE || edge_cnt == half)
        smp <= {smp[0], rx_sync};
      if (edge_cnt == half + ONE)
        bit_val <= maj3(smp[1], smp[0], rx_sync);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: FSM, shift register, parity check, outputs.
// Define UART_RX_BREAK_EN to add break detection (break_det port, BREAK state).
module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [3:0]            data_len,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  stop2,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error
`ifdef UART_RX_BREAK_EN
  ,
  output logic                  break_det
`endif
);

  localparam logic [PRESCALE_W-1:0] ONE     = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO     = PRESCALE_W'(2);
  localparam logic [PRESCALE_W-1:0] P_MIN   = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [3:0]            LEN_MIN = 4'(MIN_DATA_LEN);
  localparam logic [3:0]            LEN_MAX = 4'(DATA_W);

  rx_state_e             state, nstate, eof_next;
  logic                  rx_sync, bit_val;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] cfg_p;
  logic [3:0]            cfg_len, bit_idx;
  logic                  cfg_par_en, cfg_par_type, cfg_stop2;
  logic [DATA_W-1:0]     shreg, data_q;
  logic                  par_bad, par_bit, stop1_bad;
  logic                  at_mid, at_end, eof, ferr, start_det;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .prescale (cfg_p),
    .clr      (nstate == ST_IDLE),
    .rx_sync  (rx_sync),
    .edge_cnt (edge_cnt),
    .bit_val  (bit_val)
  );

  assign at_mid    = (edge_cnt == (cfg_p >> 1) + TWO);
  assign at_end    = (edge_cnt == cfg_p - ONE);
  assign start_det = (state == ST_IDLE) && !rx_sync;
  assign eof       = !rst && at_mid &&
                     ((state == ST_STOP1 && !cfg_stop2) || state == ST_STOP2);
  assign ferr      = (state == ST_STOP1) ? !bit_val : (stop1_bad | !bit_val);

  assign data_valid    = eof && !ferr && !par_bad;
  assign parity_error  = eof && par_bad;
  assign framing_error = eof && ferr;
  // The register only follows shreg on a clean frame, so data_out is valid with the pulse.
  assign data_out      = data_valid ? shreg : data_q;

`ifdef UART_RX_BREAK_EN
  logic brk_hit;
  assign brk_hit   = ((state == ST_STOP1) ? !bit_val : stop1_bad) &&
                     (shreg == '0) && !(cfg_par_en && par_bit);
  assign break_det = framing_error && brk_hit;
  assign eof_next  = break_det ? ST_BREAK : ST_IDLE;
`else
  assign eof_next  = ST_IDLE;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:   if (!rx_sync) nstate = ST_START;
      ST_START:  if (at_mid && bit_val) nstate = ST_IDLE;
                 else if (at_end)       nstate = ST_DATA;
      ST_DATA:   if (at_end && bit_idx == cfg_len)
                   nstate = cfg_par_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (at_end) nstate = ST_STOP1;
      ST_STOP1:  if (at_end) nstate = ST_STOP2;
      ST_STOP2:  nstate = ST_STOP2;
`ifdef UART_RX_BREAK_EN
      ST_BREAK:  if (rx_sync) nstate = ST_IDLE;
`endif
      default:   nstate = ST_IDLE;
    endcase
    if (eof) nstate = eof_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_p        <= P_MIN;
      cfg_len      <= LEN_MAX;
      cfg_par_en   <= 1'b0;
      cfg_par_type <= 1'b0;
      cfg_stop2    <= 1'b0;
      shreg        <= '0;
      bit_idx      <= '0;
      par_bad      <= 1'b0;
      par_bit      <= 1'b0;
      stop1_bad    <= 1'b0;
      data_q       <= '0;
    end else begin
      data_q <= data_out;
      // Frame configuration is frozen here; out-of-range values are clamped.
      if (start_det) begin
        cfg_p        <= (prescale < P_MIN) ? P_MIN : prescale;
        cfg_len      <= (data_len < LEN_MIN) ? LEN_MIN :
                        (data_len > LEN_MAX) ? LEN_MAX : data_len;
        cfg_par_en   <= par_en;
        cfg_par_type <= par_type;
        cfg_stop2    <= stop2;
        shreg        <= '0;
        bit_idx      <= '0;
        par_bad      <= 1'b0;
        par_bit      <= 1'b0;
        stop1_bad    <= 1'b0;
      end
      if (state == ST_DATA && at_mid) begin
        for (int i = 0; i < DATA_W; i++)
          if (bit_idx == 4'(i)) shreg[i] <= bit_val;
        bit_idx <= bit_idx + 4'd1;
      end
      if (state == ST_PARITY && at_mid) begin
        par_bit <= bit_val;
        par_bad <= bit_val != ((^shreg) ^ cfg_par_type);
      end
      if (state == ST_STOP1 && at_mid)
        stop1_bad <= !bit_val;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: frames push expected pulses, a negedge monitor pops them.
module tb_uart_rx_cfg;

  localparam int DATA_W = 8;
  localparam int PW     = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_in = 1'b1;
  logic [PW-1:0]     prescale = PW'(8);
  logic [3:0]        data_len = 4'd8;
  logic              par_en = 1'b0, par_type = 1'b0, stop2 = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid, parity_error, framing_error;
  logic              bd_w;

`ifdef UART_RX_BREAK_EN
  logic break_det;
  assign bd_w = break_det;
`else
  assign bd_w = 1'b0;
`endif

  uart_rx_cfg #(.DATA_W(DATA_W), .PRESCALE_W(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_in         (rx_in),
    .prescale      (prescale),
    .data_len      (data_len),
    .par_en        (par_en),
    .par_type      (par_type),
    .stop2         (stop2),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error)
`ifdef UART_RX_BREAK_EN
    ,
    .break_det     (break_det)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic              dv, pe, fe, bd;
    logic [DATA_W-1:0] data;
    int                at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  always @(negedge clk) begin
    if (!rst && (data_valid || parity_error || framing_error || bd_w)) begin
      checks++;
      if (sbq.size() == 0) begin
        $display("FAIL unexpected_pulse: got dv=%b pe=%b fe=%b bd=%b, expected no pulse",
                 data_valid, parity_error, framing_error, bd_w);
      end else begin
        mon_e = sbq.pop_front();
        if ({data_valid, parity_error, framing_error, bd_w} !==
            {mon_e.dv, mon_e.pe, mon_e.fe, mon_e.bd})
          $display("FAIL pulse_flags: got dv/pe/fe/bd=%b%b%b%b, expected %b%b%b%b",
                   data_valid, parity_error, framing_error, bd_w,
                   mon_e.dv, mon_e.pe, mon_e.fe, mon_e.bd);
        else passes++;
        if (mon_e.dv) begin
          checks++;
          if (data_out !== mon_e.data)
            $display("FAIL frame_data: got %h, expected %h", data_out, mon_e.data);
          else passes++;
        end
        if (mon_e.at >= 0) begin
          checks++;
          if (cyc !== mon_e.at)
            $display("FAIL pulse_cycle: got %0d, expected %0d", cyc, mon_e.at);
          else passes++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int p, input int len, input bit pe, input bit pt, input bit s2);
    prescale = PW'(p);
    data_len = 4'(len);
    par_en   = pe;
    par_type = pt;
    stop2    = s2;
  endtask

  // Drives one frame with the current configuration and queues the expected pulse.
  task automatic send_frame(input logic [DATA_W-1:0] data, input bit flip_par,
                            input bit s1, input bit s2v, input bit chk_t, input int tail_low);
    int p, len, n, t0;
    logic [DATA_W-1:0] d;
    logic pbit;
    exp_t e;
    p   = int'(prescale);
    len = int'(data_len);
    d   = '0;
    for (int i = 0; i < len; i++) d[i] = data[i];
    pbit = (^d) ^ par_type ^ flip_par;
    n    = 1 + len + int'(par_en) + 1 + int'(stop2);
    t0   = cyc;
    e.fe   = !s1 || (stop2 && !s2v);
    e.pe   = par_en && flip_par;
    e.dv   = !e.fe && !e.pe;
    e.data = d;
`ifdef UART_RX_BREAK_EN
    e.bd   = (d == '0) && !(par_en && pbit) && !s1;
`else
    e.bd   = 1'b0;
`endif
    e.at   = chk_t ? t0 + 2 + (n - 1) * p + p / 2 + 2 : -1;
    sbq.push_back(e);
    rx_in = 1'b0; tick(p);
    for (int i = 0; i < len; i++) begin rx_in = d[i]; tick(p); end
    if (par_en) begin rx_in = pbit; tick(p); end
    rx_in = s1; tick(p);
    if (stop2) begin rx_in = s2v; tick(p); end
    if (tail_low > 0) begin rx_in = 1'b0; tick(tail_low); end
    rx_in = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin tick(1); n++; end
    checks++;
    if (sbq.size() != 0) begin
      $display("FAIL %s_drain: %0d expected pulses never seen, expected 0", name, sbq.size());
      sbq.delete();
    end else passes++;
  endtask

  task automatic check_data(input string name, input logic [DATA_W-1:0] exp);
    checks++;
    if (data_out !== exp) $display("FAIL %s: data_out=%h, expected %h", name, data_out, exp);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_in = 1'b1;
    tick(3);
    checks++;
    if (data_out !== '0) $display("FAIL reset_data: got %h, expected 00", data_out);
    else passes++;
    checks++;
    if ({data_valid, parity_error, framing_error, bd_w} !== 4'b0000)
      $display("FAIL reset_pulses: got %b, expected 0000",
               {data_valid, parity_error, framing_error, bd_w});
    else passes++;
    rst = 1'b0;
    tick(4);
    checks++;
    if ({data_valid, parity_error, framing_error, bd_w} !== 4'b0000)
      $display("FAIL idle_pulses: got %b, expected 0000",
               {data_valid, parity_error, framing_error, bd_w});
    else passes++;
  endtask

  task automatic test_basic();
    set_cfg(8, 8, 0, 0, 0);
    send_frame(8'hA5, 0, 1, 1, 1, 0);
    wait_drain("basic", 100);
    check_data("basic_hold", 8'hA5);
    tick(5);
  endtask

  task automatic test_parity();
    set_cfg(16, 7, 1, 1, 1);
    send_frame(8'h3C, 0, 1, 1, 1, 0);
    wait_drain("parity_ok", 100);
    check_data("parity_ok_data", 8'h3C);
    tick(3);
    send_frame(8'h3C, 1, 1, 1, 0, 0);
    wait_drain("parity_bad", 100);
    check_data("parity_bad_hold", 8'h3C);
    tick(5);
  endtask

  task automatic test_glitch();
    set_cfg(8, 8, 0, 0, 0);
    rx_in = 1'b0; tick(2);
    rx_in = 1'b1; tick(40);
    check_data("glitch_hold", 8'h3C);
    send_frame(8'h55, 0, 1, 1, 0, 0);
    wait_drain("glitch_next", 100);
    check_data("glitch_next_data", 8'h55);
    tick(5);
  endtask

  task automatic test_framing();
    set_cfg(8, 8, 0, 0, 0);
    send_frame(8'h81, 0, 0, 1, 0, 0);
    wait_drain("framing", 100);
    tick(40);
    check_data("framing_hold", 8'h55);
  endtask

`ifdef UART_RX_BREAK_EN
  task automatic test_break();
    set_cfg(8, 8, 0, 0, 0);
    send_frame(8'h00, 0, 0, 1, 0, 24);
    wait_drain("break", 100);
    tick(20);
    check_data("break_hold", 8'h55);
    send_frame(8'h3A, 0, 1, 1, 0, 0);
    wait_drain("break_next", 100);
    check_data("break_next_data", 8'h3A);
    tick(5);
  endtask
`endif

  task automatic test_back_to_back();
    set_cfg(32, 8, 0, 0, 0);
    send_frame(8'h00, 0, 1, 1, 0, 0);
    send_frame(8'hFF, 0, 1, 1, 0, 0);
    wait_drain("b2b", 200);
    check_data("b2b_last", 8'hFF);
    tick(5);
  endtask

  task automatic test_reset_mid();
    set_cfg(8, 8, 0, 0, 0);
    rx_in = 1'b0; tick(8);
    rx_in = 1'b1; tick(8);
    rx_in = 1'b0; tick(8);
    rx_in = 1'b1; tick(4);
    rst = 1'b1;
    tick(2);
    check_data("rst_mid_data", 8'h00);
    checks++;
    if ({data_valid, parity_error, framing_error, bd_w} !== 4'b0000)
      $display("FAIL rst_mid_pulses: got %b, expected 0000",
               {data_valid, parity_error, framing_error, bd_w});
    else passes++;
    rx_in = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);
    send_frame(8'h5A, 0, 1, 1, 1, 0);
    wait_drain("rst_mid_next", 100);
    check_data("rst_mid_next_data", 8'h5A);
    tick(5);
  endtask

  initial begin
    tick(1);
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_framing();
`ifdef UART_RX_BREAK_EN
    test_break();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised, runtime-configurable UART receiver, the next generation of the transceiver's fixed 8-bit receive path. Supports:
- data widths up to DATA_W bits;
- optional even/odd parity;
- one or two stop bits;
- three-sample majority voting;
- an integrated input synchroniser.

It sits between the asynchronous serial pin and the RX clock domain's consumer, and reports each frame as a one-cycle valid pulse with per-frame error pulses.

## Interface
- DATA_W, default 8: maximum data bits per frame; legal range 5..9.
- PRESCALE_W, default 6: width of the prescale input.
- clk  input  1  receive clock (oversampling clock).
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line; idles high.
- prescale  input  PRESCALE_W  clocks per bit, P; legal values are even, 8 ≤ P ≤ 2^PRESCALE_W−2.
- data_len  input  4  data bits per frame, 5..DATA_W.
- par_en  input  1  1 = a parity bit follows the data.
- par_type  input  1  0 = even parity, 1 = odd parity.
- stop2  input  1  1 = two stop bits.
- data_out  output  DATA_W  last good frame, LSB-aligned; unused MSBs are 0.
- data_valid  output  1  one-cycle pulse when data_out updates.
- parity_error  output  1  one-cycle pulse.
- framing_error  output  1  one-cycle pulse.
- break_det  output  1  one-cycle pulse; exists only with UART_RX_BREAK_EN.

## Operation
- Input synchroniser: two flops on rx_in, both reset to 1. The FSM acts on the synchronised line only.
- Bit timing:
  - An edge counter runs 0..P−1 within each bit; h = P/2.
  - Samples are taken at edges h−1, h and h+1.
  - The majority of the three samples is the bit value and is registered at edge h+2.
- Configuration latch: prescale, data_len, par_en, par_type and stop2 are captured on the IDLE→START transition. Changes mid-frame have no effect on the frame in progress.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, plus BREAK with the macro.
  - IDLE: synchronised line low → START. That cycle is edge 0 of the start bit.
  - START: majority 1 at edge h+2 is a glitch → IDLE, with no output pulses. Otherwise → DATA at edge P−1.
  - DATA: bits shift in LSB first. After data_len bits → PARITY if par_en, else → STOP1.
  - PARITY: the received bit is compared with the XOR of the data, inverted when odd. A mismatch is recorded internally.
  - STOP1: decision at edge h+2.
    - stop2 = 1 → STOP2 (stop value recorded).
    - stop2 = 0 → end-of-frame actions, then IDLE in the same cycle.
  - STOP2: decision at edge h+2 → end-of-frame actions → IDLE.
- End-of-frame actions, all in one cycle:
  - framing_error pulses if any stop bit was 0.
  - parity_error pulses on a parity mismatch.
  - If both are clean, data_out is loaded and data_valid pulses.
  - On any error, data_out holds its previous value.
- Framing error with the line still low: IDLE immediately treats the low line as a new start bit (no macro), or BREAK handles it (with the macro).
- Reset mid-frame: FSM → IDLE, counters → 0, and the frame is discarded.

## Timing
- Reset values:
  - data_out = 0.
  - data_valid, parity_error, framing_error and break_det = 0.
  - Synchroniser flops = 1.
- Latency from the rx_in falling edge to start-bit edge 0 is 3 clk (2 synchroniser flops plus 1 for IDLE detection).
- Let N = 1 + data_len + par_en + 1 + stop2. The end-of-frame pulse occurs at cycle (N−1)·P + h + 2 after start-bit edge 0.
- The earliest next start edge 0 is one cycle after the pulse, which allows back-to-back frames at up to ≈ +P/2−3 clocks of sender clock slip.
- All pulses are exactly one cycle and are never asserted simultaneously with the next frame's pulses.

## Configuration
- UART_RX_BREAK_EN defined:
  - A frame with all data bits 0, parity (if any) 0 and the first stop bit 0 pulses break_det together with framing_error.
  - The FSM then enters BREAK, stays there until the synchronised line is high for one cycle, and returns to IDLE.
- Not defined: the break_det port and BREAK state are absent, and such a frame reports framing_error only.

## Structure
- Package uart_rx_pkg holds:
  - the FSM state enum;
  - the constants MIN_PRESCALE = 8 and MIN_DATA_LEN = 5;
  - the majority-of-three function.
- One sub-module, uart_rx_sampler, contains the synchroniser, the edge counter and the three-sample majority register. It outputs the synchronised line, edge_cnt and bit_val. The top level holds the FSM, shift register, parity check and outputs.

## Test plan
- P=8, 8 data bits, no parity, 1 stop bit, byte 0xA5 → data_out=0xA5, data_valid pulses 78 cycles after start edge 0, no error pulses.
- P=16, data_len=7, par_en=1, par_type=1, stop2=1, data 0x3C with a correct parity bit → data_out=0x3C. Repeat with the parity bit flipped → parity_error pulse only, data_out unchanged.
- Start glitch: rx_in low for 2 clocks at P=8 → no pulses, FSM back in IDLE, the next valid frame 0x55 is received correctly.
- Stop bit forced 0 on 0x81 → framing_error pulse, no data_valid. With UART_RX_BREAK_EN, a 0x00 frame with a 0 stop bit → break_det plus framing_error, and no new frame until the line returns high.
- Two back-to-back 0xFF/0x00 frames with no idle gap, P=32 → two data_valid pulses, correct data.
- rst asserted mid-DATA, then a fresh 0x5A frame → outputs 0 during reset, 0x5A received correctly.
